display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single 8-digit seven-segment display driver between NUM_REQ requesters, such as the ALU result, operand A, operand B and the flags word.
- Grants the display round-robin and holds each granted value for a minimum dwell time, so every value stays readable.
- Drives the display driver's number/load inputs.
- Sits between the ALU top level and the display driver, in the clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of each displayed value (8 hex digits).
- DWELL_CYCLES, 50_000_000, clk cycles a granted value is held before re-arbitration (1 s at 50 MHz). Legal range >= 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level. A requester holds it high until its grant bit pulses.
- req_data  input  NUM_REQ*DATA_W  flattened request values; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot, one-cycle acknowledge; the granted req_data has been captured.
- disp_number  output  DATA_W  value to the display driver's number input.
- disp_load  output  1  one-cycle load strobe to the display driver.
- owner  output  $clog2(NUM_REQ)  index of the requester currently shown.
- owner_valid  output  1  high once any value has been shown since reset.
- holding  output  1  high while the dwell timer is running.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant=0, disp_number=0, disp_load=0, owner=0, owner_valid=0, holding=0, dwell counter=0, rr pointer=NUM_REQ-1 (so requester 0 wins first).
- All outputs are registered.
- Round-robin pick: among req bits set, choose the first index searching upward from (pointer+1) mod NUM_REQ, wrapping. The pointer updates to the winner on every grant.
- FSM states: IDLE, LOAD, HOLD.
- IDLE, any req high at a clk edge → LOAD.
  - At that edge: capture the winner's req_data into disp_number and set owner=winner.
- LOAD (exactly one cycle): disp_load=1 and grant[winner]=1; set owner_valid=1. → HOLD at the next edge, with the counter cleared and holding=1.
  - Latency: req sampled high in IDLE at edge k gives grant/disp_load high in cycle k+1.
- HOLD: the counter increments each cycle, and holding=1 for exactly DWELL_CYCLES cycles. On the last HOLD cycle (counter == DWELL_CYCLES-1), arbitrate:
  - any req high → LOAD, capturing data as above, with holding=0 from that edge;
  - no req high → IDLE, holding=0.
- req is ignored during HOLD except for that final-cycle sample. Requests raised mid-dwell wait.
- A lone requester that re-asserts is re-granted after each dwell; there is no starvation because of round-robin.
- A requester may drop req before being granted. The request is withdrawn and no grant is issued to it.
- A requester may change req_data while waiting. The value captured is the one present at the capture edge.
- In IDLE the display retains the last value: disp_number and owner are unchanged and owner_valid stays 1.
- disp_number changes only on capture edges. disp_load is never high in two consecutive cycles.
- At most one grant bit is high in any cycle. grant is only high in LOAD.
- Reset mid-operation (any state): all outputs return to reset values immediately. Any pending grant is lost and requesters must keep req high.
- DWELL_CYCLES=1: HOLD lasts one cycle. Back-to-back service yields a LOAD every 2 cycles.

Decomposition:
- Package alu_disp_pkg holds:
  - typedef enum disp_arb_state_t {IDLE, LOAD, HOLD};
  - localparam DISP_DATA_W = 32;
  - localparam DISP_DWELL_DEFAULT = 50_000_000.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: winner index and any_req.
- Counter width is $clog2(DWELL_CYCLES+1).

Test Plan (DWELL_CYCLES=4, NUM_REQ=4 unless stated):
1. After reset, req[2]=1 with data 0xDEADBEEF held → grant[2] and disp_load high exactly one cycle later, disp_number=0xDEADBEEF, owner=2, holding high 4 cycles, then IDLE with the display retained.
2. req[0] and req[1] rise together after reset (0x11111111 / 0x22222222), held until granted → req0 granted first; req1 granted at the LOAD immediately after the 4-cycle dwell; disp_number sequence 0x11111111 then 0x22222222.
3. req[0], req[1] and req[3] held continuously, each dropped one cycle after its grant and re-raised → grant order 0,1,3,0,1,3; grants spaced 5 cycles apart.
4. req[1] raised in IDLE after owner=1, then dropped before the capture edge while req[3] stays high → req3 granted; req1 never granted.
5. Assert rst_n low during HOLD cycle 2 → all outputs return to 0 asynchronously. After release, a held req[0] is granted as in scenario 1.
6. DWELL_CYCLES=1, req[0] held continuously → disp_load pulses every 2nd cycle, grant[0] each time, owner constant 0.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: shared types and defaults for the display arbiter.
package alu_disp_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} disp_arb_state_t;
   localparam int DISP_DATA_W = 32;
   localparam int DISP_DWELL_DEFAULT = 50_000_000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, searching upward from ptr+1 with wrap.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [PW-1:0]      winner,
   output logic               any_req
);
   logic [PW-1:0] w_idx;
   // Walk from the farthest offset down so the nearest set request wins last.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      w_idx   = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (req[w_idx]) begin
            winner  = w_idx;
            any_req = 1'b1;
         end
      end
   end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the seven-segment display with a minimum dwell per value.
module display_arbiter
   import alu_disp_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = DISP_DATA_W,
   parameter int DWELL_CYCLES = DISP_DWELL_DEFAULT,
   parameter int PW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [DATA_W-1:0]         disp_number,
   output logic                      disp_load,
   output logic [PW-1:0]             owner,
   output logic                      owner_valid,
   output logic                      holding
);
   localparam int CW = $clog2(DWELL_CYCLES + 1);
   disp_arb_state_t r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [PW-1:0]      r_ptr, w_win;
   logic               w_any, w_last, w_cap;
   logic [NUM_REQ-1:0] r_grant;
   logic [DATA_W-1:0]  r_number;
   logic [PW-1:0]      r_owner;
   logic               r_load, r_valid, r_holding;

   rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .winner  (w_win),
      .any_req (w_any)
   );

   // Requests are only sampled in IDLE or on the final dwell cycle.
   always_comb begin
      w_next = r_state;
      w_last = (r_state == HOLD) && (r_cnt == CW'(DWELL_CYCLES - 1));
      w_cap  = w_any && ((r_state == IDLE) || w_last);
      w_next = w_cap ? LOAD : (r_state == LOAD) ? HOLD : w_last ? IDLE : r_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant   <= '0;
         r_number  <= '0;
         r_load    <= 1'b0;
         r_owner   <= '0;
         r_valid   <= 1'b0;
         r_holding <= 1'b0;
         r_cnt     <= '0;
         r_ptr     <= PW'(NUM_REQ - 1);
      end else begin
         r_grant   <= w_cap ? (NUM_REQ'(1) << w_win) : '0;
         r_load    <= w_cap;
         r_holding <= (w_next == HOLD);
         r_cnt     <= (r_state == HOLD) ? r_cnt + CW'(1) : '0;
         if (w_cap) begin
            r_number <= req_data[w_win*DATA_W +: DATA_W];
            r_owner  <= w_win;
            r_ptr    <= w_win;
            r_valid  <= 1'b1;
         end
      end
   end

   assign grant       = r_grant;
   assign disp_number = r_number;
   assign disp_load   = r_load;
   assign owner       = r_owner;
   assign owner_valid = r_valid;
   assign holding     = r_holding;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of round-robin grant, dwell timing, withdrawal and reset.
module tb_display_arbiter;
   logic         clk = 1'b0;
   logic         rst_n, rst_nb;
   logic [3:0]   req, req_b;
   logic [127:0] rd, rd_b;
   logic [3:0]   grant, grant_b;
   logic [31:0]  num, num_b;
   logic         load, load_b, ov, ov_b, hold, hold_b;
   logic [1:0]   own, own_b;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   display_arbiter #(.NUM_REQ(4), .DATA_W(32), .DWELL_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(rd), .grant(grant),
      .disp_number(num), .disp_load(load), .owner(own), .owner_valid(ov), .holding(hold)
   );

   display_arbiter #(.NUM_REQ(4), .DATA_W(32), .DWELL_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_nb), .req(req_b), .req_data(rd_b), .grant(grant_b),
      .disp_number(num_b), .disp_load(load_b), .owner(own_b), .owner_valid(ov_b), .holding(hold_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_load(input string tag, input logic [3:0] g, input logic [31:0] d, input logic [1:0] o);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_load"}, 32'(load), 32'd1);
      chk({tag, "_num"}, num, d);
      chk({tag, "_owner"}, 32'(own), 32'(o));
      chk({tag, "_hold"}, 32'(hold), 32'd0);
   endtask

   task automatic chk_dwell(input string tag, input logic [31:0] d);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk({tag, "_dwell_hold"}, 32'(hold), 32'd1);
         chk({tag, "_dwell_grant"}, 32'(grant), 32'd0);
         chk({tag, "_dwell_load"}, 32'(load), 32'd0);
         chk({tag, "_dwell_num"}, num, d);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; rst_nb = 1'b0; req = '0; req_b = '0; rd = '0; rd_b = '0;
      cyc();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_num", num, 32'd0);
      chk("rst_load", 32'(load), 32'd0);
      chk("rst_owner", 32'(own), 32'd0);
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_hold", 32'(hold), 32'd0);
      rst_n = 1'b1;
      // single requester 2
      cyc();
      req = 4'b0100; rd[64 +: 32] = 32'hDEADBEEF;
      chk("s1_pre_grant", 32'(grant), 32'd0);
      cyc();
      chk_load("s1", 4'b0100, 32'hDEADBEEF, 2'd2);
      chk("s1_valid", 32'(ov), 32'd1);
      req = '0;
      chk_dwell("s1", 32'hDEADBEEF);
      cyc();
      chk("s1_idle_hold", 32'(hold), 32'd0);
      chk("s1_idle_num", num, 32'hDEADBEEF);
      chk("s1_idle_owner", 32'(own), 32'd2);
      chk("s1_idle_valid", 32'(ov), 32'd1);
      cyc();
      chk("s1_idle_load", 32'(load), 32'd0);
      // two simultaneous requesters; req1 data changes while waiting
      do_reset();
      req = 4'b0011; rd[0 +: 32] = 32'h11111111; rd[32 +: 32] = 32'h2222AAAA;
      cyc();
      chk_load("s2a", 4'b0001, 32'h11111111, 2'd0);
      req = 4'b0010;
      rd[32 +: 32] = 32'h22222222;
      chk_dwell("s2a", 32'h11111111);
      cyc();
      chk_load("s2b", 4'b0010, 32'h22222222, 2'd1);
      req = '0;
      chk_dwell("s2b", 32'h22222222);
      cyc();
      chk("s2_idle_hold", 32'(hold), 32'd0);
      // req1 raised then withdrawn before the capture edge, req3 stays
      req = 4'b0010; rd[96 +: 32] = 32'h33333333;
      #3 req = 4'b1000;
      cyc();
      chk_load("s4", 4'b1000, 32'h33333333, 2'd3);
      req = '0;
      chk_dwell("s4", 32'h33333333);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s4_no_grant", 32'(grant), 32'd0);
         chk("s4_idle_load", 32'(load), 32'd0);
      end
      // three continuous requesters, order 0,1,3 repeating every 5 cycles
      do_reset();
      rd[0 +: 32] = 32'hA0; rd[32 +: 32] = 32'hA1; rd[96 +: 32] = 32'hA3;
      req = 4'b1011;
      for (int g = 0; g < 6; g++) begin
         logic [1:0] e;
         e = (g % 3 == 0) ? 2'd0 : (g % 3 == 1) ? 2'd1 : 2'd3;
         cyc();
         chk_load("s3", 4'(1 << e), 32'hA0 | 32'(e), e);
         if (g == 5) break;
         req[e] = 1'b0;
         cyc();
         chk("s3_gap_grant", 32'(grant), 32'd0);
         req[e] = 1'b1;
         for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s3_gap_grant", 32'(grant), 32'd0);
         end
      end
      // reset during HOLD cycle 2
      req = 4'b0001;
      cyc();
      cyc();
      chk("s5_pre_hold", 32'(hold), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("s5_async_grant", 32'(grant), 32'd0);
      chk("s5_async_num", num, 32'd0);
      chk("s5_async_owner", 32'(own), 32'd0);
      chk("s5_async_valid", 32'(ov), 32'd0);
      chk("s5_async_hold", 32'(hold), 32'd0);
      chk("s5_async_load", 32'(load), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_load("s5", 4'b0001, 32'hA0, 2'd0);
      req = '0;
      chk_dwell("s5", 32'hA0);
      // DWELL_CYCLES=1 back-to-back service of requester 0
      rst_nb = 1'b1; req_b = 4'b0001; rd_b[0 +: 32] = 32'hC0FFEE00;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s6_load", 32'(load_b), 32'd1);
         chk("s6_grant", 32'(grant_b), 32'd1);
         chk("s6_owner", 32'(own_b), 32'd0);
         chk("s6_num", num_b, 32'hC0FFEE00);
         cyc();
         chk("s6_gap_load", 32'(load_b), 32'd0);
         chk("s6_gap_grant", 32'(grant_b), 32'd0);
         chk("s6_gap_hold", 32'(hold_b), 32'd1);
         chk("s6_gap_owner", 32'(own_b), 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
